// File: rtl/execute_ldst_pipe_pkg.sv
// Load/store definitions shared by the memory ports: order encodings,
// lane masks, store lane replication and load alignment/extension.
package execute_ldst_pipe_pkg;

   localparam logic [1:0] LDST_ORDER_BYTE = 2'b00;
   localparam logic [1:0] LDST_ORDER_HALF = 2'b01;
   localparam logic [1:0] LDST_ORDER_WORD = 2'b10;

   typedef struct packed {
      logic       rw;
      logic [1:0] order;
      logic [1:0] lane;
      logic       sign;
   } ldst_attr_t;

   localparam int LDST_ATTR_W = $bits(ldst_attr_t);

   // Order 2'b11 falls into the word case everywhere.
   function automatic logic [3:0] ldst_mask(
      input logic [1:0] order,
      input logic [1:0] lane
   );
      logic [3:0] m;
      m = 4'b1111;
      unique case (1'b1)
         (order == LDST_ORDER_BYTE): m = 4'b0001 << lane;
         (order == LDST_ORDER_HALF): m = lane[1] ? 4'b1100 : 4'b0011;
         default:                    m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] ldst_store_data(
      input logic [1:0]  order,
      input logic [31:0] data
   );
      logic [31:0] r;
      r = data;
      unique case (1'b1)
         (order == LDST_ORDER_BYTE): r = {4{data[7:0]}};
         (order == LDST_ORDER_HALF): r = {2{data[15:0]}};
         default:                    r = data;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] ldst_load_data(
      input logic [1:0]  order,
      input logic [1:0]  lane,
      input logic        sign,
      input logic [31:0] data
   );
      logic [31:0] r;
      logic [7:0]  b;
      logic [15:0] h;
      r = data;
      b = data[{lane, 3'b000} +: 8];
      h = lane[1] ? data[31:16] : data[15:0];
      unique case (1'b1)
         (order == LDST_ORDER_BYTE): r = {{24{sign & b[7]}}, b};
         (order == LDST_ORDER_HALF): r = {{16{sign & h[15]}}, h};
         default:                    r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ldst_outstanding_fifo.sv
// Register FIFO holding metadata of issued data-port requests;
// responses come back in order and pop the head.
module ldst_outstanding_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 8,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/execute_ldst_pipe.sv
// Load/store execute port: one-entry issue register, in-order
// outstanding tracking, load alignment and flush discard.
module execute_ldst_pipe
   import execute_ldst_pipe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 6,
   parameter int REG_W = 6,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             iCLOCK,
   input  logic             inRESET,
   input  logic             iRESET_SYNC,
   input  logic             iREQ_VALID,
   output logic             oREQ_LOCK,
   input  logic             iREQ_RW,
   input  logic [1:0]       iREQ_ORDER,
   input  logic             iREQ_SIGNED,
   input  logic [31:0]      iREQ_ADDR,
   input  logic [31:0]      iREQ_DATA,
   input  logic [TAG_W-1:0] iREQ_COMMIT_TAG,
   input  logic [REG_W-1:0] iREQ_DEST_REGNAME,
   output logic             oDATAIO_REQ,
   input  logic             iDATAIO_BUSY,
   output logic             oDATAIO_RW,
   output logic [1:0]       oDATAIO_ORDER,
   output logic [3:0]       oDATAIO_MASK,
   output logic [31:0]      oDATAIO_ADDR,
   output logic [31:0]      oDATAIO_DATA,
   input  logic             iDATAIO_REQ,
   input  logic [31:0]      iDATAIO_DATA,
   output logic             oWB_VALID,
   output logic             oWB_WRITEBACK,
   output logic [TAG_W-1:0] oWB_COMMIT_TAG,
   output logic [REG_W-1:0] oWB_DEST_REGNAME,
   output logic [31:0]      oWB_DATA,
   output logic [CNT_W-1:0] oOUTSTANDING,
   output logic             oPROTOCOL_ERR
);

   localparam int META_W = TAG_W + REG_W + LDST_ATTR_W;

   logic             b_issue_valid;
   logic             b_issue_rw;
   logic [1:0]       b_issue_order;
   logic             b_issue_signed;
   logic [31:0]      b_issue_addr;
   logic [31:0]      b_issue_data;
   logic [TAG_W-1:0] b_issue_tag;
   logic [REG_W-1:0] b_issue_reg;
   logic [CNT_W-1:0] b_discard;
   logic             b_protocol_err;

   logic             issue_fire;
   logic             accept;
   logic             discarding;
   logic             resp_drop;
   logic             resp_pop;
   logic             resp_stray;
   logic             wb_fire;
   logic [CNT_W-1:0] discard_next;

   logic [META_W-1:0] push_meta;
   logic [META_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   ldst_attr_t        push_attr;
   ldst_attr_t        head_attr;
   logic [TAG_W-1:0]  head_tag;
   logic [REG_W-1:0]  head_reg;

   // Full check uses registered occupancy; a pop this cycle does not help.
   assign oDATAIO_REQ = b_issue_valid && !fifo_full && !iRESET_SYNC;
   assign issue_fire  = oDATAIO_REQ && !iDATAIO_BUSY;
   assign discarding  = (b_discard != '0);
   assign oREQ_LOCK   = (b_issue_valid && !issue_fire) || discarding;
   assign accept      = iREQ_VALID && !oREQ_LOCK;

   assign resp_drop  = iDATAIO_REQ && discarding;
   assign resp_pop   = iDATAIO_REQ && !discarding && !fifo_empty;
   assign resp_stray = iDATAIO_REQ && !discarding && fifo_empty;
   assign wb_fire    = resp_pop && !iRESET_SYNC;

   assign discard_next = b_discard + fifo_count
                       - CNT_W'(resp_drop || resp_pop);

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         b_issue_valid  <= 1'b0;
         b_issue_rw     <= 1'b0;
         b_issue_order  <= '0;
         b_issue_signed <= 1'b0;
         b_issue_addr   <= '0;
         b_issue_data   <= '0;
         b_issue_tag    <= '0;
         b_issue_reg    <= '0;
      end else if (iRESET_SYNC) begin
         b_issue_valid <= 1'b0;
      end else if (accept) begin
         b_issue_valid  <= 1'b1;
         b_issue_rw     <= iREQ_RW;
         b_issue_order  <= iREQ_ORDER;
         b_issue_signed <= iREQ_SIGNED;
         b_issue_addr   <= iREQ_ADDR;
         b_issue_data   <= iREQ_DATA;
         b_issue_tag    <= iREQ_COMMIT_TAG;
         b_issue_reg    <= iREQ_DEST_REGNAME;
      end else if (issue_fire) begin
         b_issue_valid <= 1'b0;
      end
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         b_discard      <= '0;
         b_protocol_err <= 1'b0;
      end else begin
         if (iRESET_SYNC)    b_discard <= discard_next;
         else if (resp_drop) b_discard <= b_discard - CNT_W'(1);
         if (resp_stray) b_protocol_err <= 1'b1;
      end
   end

   always_comb begin
      push_attr       = '0;
      push_attr.rw    = b_issue_rw;
      push_attr.order = b_issue_order;
      push_attr.lane  = b_issue_addr[1:0];
      push_attr.sign  = b_issue_signed;
   end

   assign push_meta = {b_issue_tag, b_issue_reg, push_attr};

   ldst_outstanding_fifo #(
      .DEPTH (DEPTH),
      .W     (META_W)
   ) u_fifo (
      .clk       (iCLOCK),
      .rst_n     (inRESET),
      .flush     (iRESET_SYNC),
      .push      (issue_fire),
      .push_data (push_meta),
      .pop       (resp_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_tag  = fifo_head[META_W-1 -: TAG_W];
   assign head_reg  = fifo_head[LDST_ATTR_W +: REG_W];
   assign head_attr = ldst_attr_t'(fifo_head[LDST_ATTR_W-1:0]);

   // Attributes read as zero whenever nothing is being offered.
   always_comb begin
      oDATAIO_RW    = 1'b0;
      oDATAIO_ORDER = '0;
      oDATAIO_MASK  = '0;
      oDATAIO_ADDR  = '0;
      oDATAIO_DATA  = '0;
      if (b_issue_valid) begin
         oDATAIO_RW    = b_issue_rw;
         oDATAIO_ORDER = b_issue_order;
         oDATAIO_MASK  = ldst_mask(b_issue_order, b_issue_addr[1:0]);
         oDATAIO_ADDR  = {b_issue_addr[31:2], 2'b00};
         oDATAIO_DATA  = ldst_store_data(b_issue_order, b_issue_data);
      end
   end

   always_comb begin
      oWB_VALID        = wb_fire;
      oWB_WRITEBACK    = 1'b0;
      oWB_COMMIT_TAG   = '0;
      oWB_DEST_REGNAME = '0;
      oWB_DATA         = '0;
      if (wb_fire) begin
         oWB_WRITEBACK    = !head_attr.rw;
         oWB_COMMIT_TAG   = head_tag;
         oWB_DEST_REGNAME = head_reg;
         if (!head_attr.rw) begin
            oWB_DATA = ldst_load_data(head_attr.order, head_attr.lane,
                                      head_attr.sign, iDATAIO_DATA);
         end
      end
   end

   assign oOUTSTANDING  = fifo_count;
   assign oPROTOCOL_ERR = b_protocol_err;

endmodule

// File: tb/tb_execute_ldst_pipe.sv
// Self-checking bench for execute_ldst_pipe: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_execute_ldst_pipe;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_lock;
   logic        req_rw;
   logic [1:0]  req_order;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [5:0]  req_tag;
   logic [5:0]  req_reg;
   logic        dreq;
   logic        dbusy;
   logic        drw;
   logic [1:0]  dorder;
   logic [3:0]  dmask;
   logic [31:0] daddr;
   logic [31:0] ddata;
   logic        dresp;
   logic [31:0] drdata;
   logic        wb_valid;
   logic        wb_wr;
   logic [5:0]  wb_tag;
   logic [5:0]  wb_reg;
   logic [31:0] wb_data;
   logic [CNT_W-1:0] outstanding;
   logic        perr;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic        rw;
      logic [1:0]  order;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] data;
      logic [5:0]  tag;
      logic [5:0]  rn;
   } op_t;

   execute_ldst_pipe #(.DEPTH(DEPTH), .TAG_W(6), .REG_W(6)) dut (
      .iCLOCK            (clk),
      .inRESET           (rst_n),
      .iRESET_SYNC       (flush),
      .iREQ_VALID        (req_valid),
      .oREQ_LOCK         (req_lock),
      .iREQ_RW           (req_rw),
      .iREQ_ORDER        (req_order),
      .iREQ_SIGNED       (req_signed),
      .iREQ_ADDR         (req_addr),
      .iREQ_DATA         (req_data),
      .iREQ_COMMIT_TAG   (req_tag),
      .iREQ_DEST_REGNAME (req_reg),
      .oDATAIO_REQ       (dreq),
      .iDATAIO_BUSY      (dbusy),
      .oDATAIO_RW        (drw),
      .oDATAIO_ORDER     (dorder),
      .oDATAIO_MASK      (dmask),
      .oDATAIO_ADDR      (daddr),
      .oDATAIO_DATA      (ddata),
      .iDATAIO_REQ       (dresp),
      .iDATAIO_DATA      (drdata),
      .oWB_VALID         (wb_valid),
      .oWB_WRITEBACK     (wb_wr),
      .oWB_COMMIT_TAG    (wb_tag),
      .oWB_DEST_REGNAME  (wb_reg),
      .oWB_DATA          (wb_data),
      .oOUTSTANDING      (outstanding),
      .oPROTOCOL_ERR     (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   function automatic logic [3:0] ref_mask(input logic [1:0] order, input int a);
      if (order == 2'd0) return 4'(1 << a);
      if (order == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] ref_store(input logic [1:0] order, input logic [31:0] d);
      if (order == 2'd0) return (d & 32'hFF) * 32'h01010101;
      if (order == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] order, input int a,
                                            input logic sgn, input logic [31:0] d);
      logic [31:0] v;
      if (order == 2'd0) begin
         v = (d >> (8 * a)) & 32'hFF;
         if (sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
         return v;
      end
      if (order == 2'd1) begin
         v = (d >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
         if (sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
         return v;
      end
      return d;
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; req_valid = 0; req_rw = 0; req_order = 0; req_signed = 0;
      req_addr = 0; req_data = 0; req_tag = 0; req_reg = 0;
      dbusy = 0; dresp = 0; drdata = 0;
   endtask

   task automatic offer(input logic rw, input logic [1:0] order, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [5:0] tag, input logic [5:0] rn);
      req_valid = 1; req_rw = rw; req_order = order; req_signed = sgn;
      req_addr = addr; req_data = data; req_tag = tag; req_reg = rn;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      #22;
      checks++; if (req_lock !== 1'b0) $display("FAIL reset_lock got=%0h exp=0", req_lock); else passed++;
      checks++; if (dreq !== 1'b0) $display("FAIL reset_dreq got=%0h exp=0", dreq); else passed++;
      checks++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); else passed++;
      checks++; if (outstanding !== '0) $display("FAIL reset_outstanding got=%0d exp=0", outstanding); else passed++;
      checks++; if (perr !== 1'b0) $display("FAIL reset_perr got=%0h exp=0", perr); else passed++;
      checks++; if ({dmask, daddr, ddata} !== '0) $display("FAIL reset_attrs got=%h/%h/%h exp=0", dmask, daddr, ddata); else passed++;
      rst_n = 1;
      next_cycle();
   endtask

   task automatic test_word_load();
      offer(0, 2'b10, 0, 32'h104, 32'h0, 6'd5, 6'd9);
      #1;
      checks++; if (req_lock !== 1'b0) $display("FAIL word_lock got=%0h exp=0", req_lock); else passed++;
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (dreq !== 1'b1) $display("FAIL word_dreq got=%0h exp=1", dreq); else passed++;
      checks++; if (dmask !== 4'b1111) $display("FAIL word_mask got=%b exp=1111", dmask); else passed++;
      checks++; if (daddr !== 32'h104) $display("FAIL word_addr got=%h exp=00000104", daddr); else passed++;
      next_cycle();
      dresp = 1; drdata = 32'hDEADBEEF;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_wr !== 1'b1) $display("FAIL word_wb got=%0h/%0h exp=1/1", wb_valid, wb_wr); else passed++;
      checks++; if (wb_data !== 32'hDEADBEEF) $display("FAIL word_data got=%h exp=deadbeef", wb_data); else passed++;
      checks++; if (wb_tag !== 6'd5 || wb_reg !== 6'd9) $display("FAIL word_tag got=%0d/%0d exp=5/9", wb_tag, wb_reg); else passed++;
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (outstanding !== '0) $display("FAIL word_drain got=%0d exp=0", outstanding); else passed++;
   endtask

   task automatic test_byte_load();
      logic [31:0] exp_v;
      for (int s = 0; s < 2; s++) begin
         exp_v = (s == 1) ? 32'hFFFFFF80 : 32'h00000080;
         offer(0, 2'b00, s[0], 32'h103, 32'h0, 6'(10 + s), 6'd3);
         next_cycle();
         idle_inputs();
         #1;
         checks++; if (dmask !== 4'b1000) $display("FAIL byte_mask got=%b exp=1000", dmask); else passed++;
         checks++; if (daddr !== 32'h100) $display("FAIL byte_addr got=%h exp=00000100", daddr); else passed++;
         next_cycle();
         dresp = 1; drdata = 32'h80123456;
         #1;
         checks++; if (wb_valid !== 1'b1 || wb_data !== exp_v) $display("FAIL byte_data s=%0d got=%0h/%h exp=1/%h", s, wb_valid, wb_data, exp_v); else passed++;
         next_cycle();
         idle_inputs();
      end
   endtask

   task automatic test_half_store();
      offer(1, 2'b01, 0, 32'h202, 32'h0000ABCD, 6'd20, 6'd4);
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (dmask !== 4'b1100) $display("FAIL half_mask got=%b exp=1100", dmask); else passed++;
      checks++; if (ddata !== 32'hABCDABCD) $display("FAIL half_data got=%h exp=abcdabcd", ddata); else passed++;
      checks++; if (drw !== 1'b1 || daddr !== 32'h200) $display("FAIL half_attr got=%0h/%h exp=1/00000200", drw, daddr); else passed++;
      next_cycle();
      dresp = 1; drdata = $urandom;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_wr !== 1'b0) $display("FAIL half_ack got=%0h/%0h exp=1/0", wb_valid, wb_wr); else passed++;
      checks++; if (wb_data !== 32'h0 || wb_tag !== 6'd20) $display("FAIL half_ack_data got=%h/%0d exp=0/20", wb_data, wb_tag); else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_full();
      logic [31:0] d;
      for (int k = 0; k < 5; k++) begin
         offer(0, 2'b10, 0, 32'h1000 + 4 * k, 32'h0, 6'(32 + k), 6'(k));
         #1;
         checks++; if (req_lock !== 1'b0) $display("FAIL full_accept k=%0d got=%0h exp=0", k, req_lock); else passed++;
         next_cycle();
      end
      idle_inputs();
      for (int r = 0; r < 2; r++) begin
         #1;
         checks++; if (outstanding !== CNT_W'(4)) $display("FAIL full_count got=%0d exp=4", outstanding); else passed++;
         checks++; if (dreq !== 1'b0 || req_lock !== 1'b1) $display("FAIL full_block got=%0h/%0h exp=0/1", dreq, req_lock); else passed++;
         next_cycle();
      end
      dresp = 1; drdata = 32'hA0000000;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_tag !== 6'd32) $display("FAIL full_pop got=%0h/%0d exp=1/32", wb_valid, wb_tag); else passed++;
      checks++; if (dreq !== 1'b0) $display("FAIL full_same_cycle got=%0h exp=0", dreq); else passed++;
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (dreq !== 1'b1 || daddr !== 32'h1010) $display("FAIL full_fifth got=%0h/%h exp=1/00001010", dreq, daddr); else passed++;
      checks++; if (outstanding !== CNT_W'(3)) $display("FAIL full_after_pop got=%0d exp=3", outstanding); else passed++;
      next_cycle();
      for (int j = 1; j < 5; j++) begin
         d = $urandom;
         dresp = 1; drdata = d;
         #1;
         checks++; if (wb_valid !== 1'b1 || wb_tag !== 6'(32 + j) || wb_data !== d) $display("FAIL full_drain j=%0d got=%0h/%0d/%h exp=1/%0d/%h", j, wb_valid, wb_tag, wb_data, 32 + j, d); else passed++;
         next_cycle();
      end
      idle_inputs();
      #1;
      checks++; if (outstanding !== '0) $display("FAIL full_empty got=%0d exp=0", outstanding); else passed++;
   endtask

   task automatic test_busy();
      logic [31:0] d;
      d = $urandom;
      dbusy = 1;
      offer(1, 2'b10, 0, 32'h301, d, 6'd44, 6'd7);
      next_cycle();
      req_valid = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (dreq !== 1'b1 || req_lock !== 1'b1) $display("FAIL busy_hold c=%0d got=%0h/%0h exp=1/1", c, dreq, req_lock); else passed++;
         checks++; if (daddr !== 32'h300 || dmask !== 4'hF || ddata !== d) $display("FAIL busy_stable c=%0d got=%h/%h/%h exp=00000300/f/%h", c, daddr, dmask, ddata, d); else passed++;
         checks++; if (outstanding !== '0) $display("FAIL busy_count c=%0d got=%0d exp=0", c, outstanding); else passed++;
         next_cycle();
      end
      dbusy = 0;
      #1;
      checks++; if (req_lock !== 1'b0) $display("FAIL busy_release got=%0h exp=0", req_lock); else passed++;
      next_cycle();
      #1;
      checks++; if (outstanding !== CNT_W'(1) || dreq !== 1'b0) $display("FAIL busy_push got=%0d/%0h exp=1/0", outstanding, dreq); else passed++;
      dresp = 1; drdata = $urandom;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_wr !== 1'b0 || wb_tag !== 6'd44) $display("FAIL busy_ack got=%0h/%0h/%0d exp=1/0/44", wb_valid, wb_wr, wb_tag); else passed++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_random();
      op_t held[$];
      op_t outq[$];
      op_t nop;
      op_t h;
      logic exp_dreq, fire, exp_lock, draining;
      logic [31:0] exp_d;
      for (int c = 0; c < 700; c++) begin
         draining = (c >= 600);
         nop.rw = 1'($urandom); nop.order = 2'($urandom_range(0, 3));
         nop.sgn = 1'($urandom); nop.addr = $urandom; nop.data = $urandom;
         nop.tag = 6'($urandom); nop.rn = 6'($urandom);
         offer(nop.rw, nop.order, nop.sgn, nop.addr, nop.data, nop.tag, nop.rn);
         req_valid = !draining && ($urandom_range(0, 3) != 0);
         dbusy = !draining && ($urandom_range(0, 3) == 0);
         dresp = (outq.size() > 0) && (draining || $urandom_range(0, 2) == 0);
         drdata = $urandom;
         #1;
         exp_dreq = (held.size() > 0) && (outq.size() < DEPTH);
         checks++; if (dreq !== exp_dreq) $display("FAIL rnd_dreq c=%0d got=%0h exp=%0h", c, dreq, exp_dreq); else passed++;
         if (exp_dreq) begin
            h = held[0];
            checks++; if (daddr !== {h.addr[31:2], 2'b00} || dmask !== ref_mask(h.order, int'(h.addr[1:0]))) $display("FAIL rnd_attr c=%0d got=%h/%b exp=%h/%b", c, daddr, dmask, {h.addr[31:2], 2'b00}, ref_mask(h.order, int'(h.addr[1:0]))); else passed++;
            if (h.rw) begin
               checks++; if (ddata !== ref_store(h.order, h.data)) $display("FAIL rnd_sdata c=%0d got=%h exp=%h", c, ddata, ref_store(h.order, h.data)); else passed++;
            end
         end
         fire = exp_dreq && !dbusy;
         exp_lock = (held.size() > 0) && !fire;
         checks++; if (req_lock !== exp_lock) $display("FAIL rnd_lock c=%0d got=%0h exp=%0h", c, req_lock, exp_lock); else passed++;
         checks++; if (outstanding !== CNT_W'(outq.size())) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, outstanding, outq.size()); else passed++;
         checks++; if (wb_valid !== dresp) $display("FAIL rnd_wb_valid c=%0d got=%0h exp=%0h", c, wb_valid, dresp); else passed++;
         if (dresp) begin
            h = outq.pop_front();
            exp_d = h.rw ? 32'h0 : ref_load(h.order, int'(h.addr[1:0]), h.sgn, drdata);
            checks++; if (wb_tag !== h.tag || wb_reg !== h.rn || wb_wr !== !h.rw || wb_data !== exp_d) $display("FAIL rnd_wb c=%0d got=%0d/%0d/%0h/%h exp=%0d/%0d/%0h/%h", c, wb_tag, wb_reg, wb_wr, wb_data, h.tag, h.rn, !h.rw, exp_d); else passed++;
         end
         if (fire) outq.push_back(held.pop_front());
         if (req_valid && !exp_lock) held.push_back(nop);
         next_cycle();
      end
      idle_inputs();
      #1;
      checks++; if (outstanding !== '0 || dreq !== 1'b0) $display("FAIL rnd_end got=%0d/%0h exp=0/0", outstanding, dreq); else passed++;
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) begin
         offer(0, 2'b10, 0, 32'h2000 + 4 * k, 32'h0, 6'(1 + k), 6'd1);
         next_cycle();
      end
      offer(0, 2'b10, 0, 32'h2100, 32'h0, 6'd60, 6'd1);
      next_cycle();
      idle_inputs();
      flush = 1;
      #1;
      checks++; if (outstanding !== CNT_W'(3)) $display("FAIL flush_pre_count got=%0d exp=3", outstanding); else passed++;
      checks++; if (dreq !== 1'b0) $display("FAIL flush_cancel got=%0h exp=0", dreq); else passed++;
      next_cycle();
      flush = 0;
      #1;
      checks++; if (outstanding !== '0 || dreq !== 1'b0) $display("FAIL flush_clear got=%0d/%0h exp=0/0", outstanding, dreq); else passed++;
      for (int j = 0; j < 3; j++) begin
         dresp = 1; drdata = $urandom;
         #1;
         checks++; if (wb_valid !== 1'b0 || req_lock !== 1'b1) $display("FAIL flush_discard j=%0d got=%0h/%0h exp=0/1", j, wb_valid, req_lock); else passed++;
         next_cycle();
      end
      idle_inputs();
      #1;
      checks++; if (req_lock !== 1'b0) $display("FAIL flush_unlock got=%0h exp=0", req_lock); else passed++;
      offer(0, 2'b10, 0, 32'h400, 32'h0, 6'd50, 6'd2);
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (dreq !== 1'b1) $display("FAIL flush_new_dreq got=%0h exp=1", dreq); else passed++;
      next_cycle();
      dresp = 1; drdata = 32'h12345678;
      #1;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h12345678 || wb_tag !== 6'd50) $display("FAIL flush_new_wb got=%0h/%h/%0d exp=1/12345678/50", wb_valid, wb_data, wb_tag); else passed++;
      checks++; if (perr !== 1'b0) $display("FAIL flush_perr got=%0h exp=0", perr); else passed++;
      next_cycle();
      idle_inputs();
      dresp = 1; drdata = $urandom;
      #1;
      checks++; if (wb_valid !== 1'b0) $display("FAIL stray_wb got=%0h exp=0", wb_valid); else passed++;
      next_cycle();
      idle_inputs();
      #1;
      checks++; if (perr !== 1'b1) $display("FAIL stray_perr got=%0h exp=1", perr); else passed++;
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_full();
      test_busy();
      test_random();
      test_flush();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/execute_ldst_pipe.md
# execute_ldst_pipe

Parametrised load/store execute port for the MIST1032SA out-of-order core. It accepts one decoded memory operation per cycle from scheduler 2, issues it to the data port under a busy handshake, and keeps up to DEPTH requests outstanding. Responses return in order and are matched to a metadata FIFO; load data is lane-aligned and sign- or zero-extended before writeback to scheduler 1/2. A flush drains in-flight responses silently.

## Interface
- DEPTH, 4, maximum outstanding data-port requests; power of two, 2..16
- TAG_W, 6, commit-tag width
- REG_W, 6, physical destination register name width
- iCLOCK  in  1  clock, all state on rising edge
- inRESET  in  1  asynchronous active-low reset
- iRESET_SYNC  in  1  synchronous flush, active high
- iREQ_VALID  in  1  operation offered
- oREQ_LOCK  out  1  operation not accepted this cycle
- iREQ_RW  in  1  0 = load, 1 = store
- iREQ_ORDER  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- iREQ_SIGNED  in  1  sign-extend load result
- iREQ_ADDR / iREQ_DATA  in  32 / 32  byte address / store data (right-justified)
- iREQ_COMMIT_TAG / iREQ_DEST_REGNAME  in  TAG_W / REG_W  writeback metadata
- oDATAIO_REQ  out  1  request strobe; iDATAIO_BUSY  in  1  port cannot accept
- oDATAIO_RW / oDATAIO_ORDER / oDATAIO_MASK  out  1 / 2 / 4  issued request attributes
- oDATAIO_ADDR / oDATAIO_DATA  out  32 / 32  word-aligned address / lane-replicated store data
- iDATAIO_REQ  in  1  response valid (load data or store ack), in issue order
- iDATAIO_DATA  in  32  response data
- oWB_VALID / oWB_WRITEBACK  out  1 / 1  completion / register write (loads only)
- oWB_COMMIT_TAG / oWB_DEST_REGNAME / oWB_DATA  out  TAG_W / REG_W / 32
- oOUTSTANDING  out  $clog2(DEPTH+1)  live FIFO occupancy
- oPROTOCOL_ERR  out  1  sticky: response received with nothing outstanding

## Operation
- Issue register, one entry. Accepts when iREQ_VALID && !oREQ_LOCK.
- oREQ_LOCK = b_issue_valid && !issue_fire, OR b_discard != 0.
- oDATAIO_REQ = b_issue_valid && count != DEPTH; issue_fire = oDATAIO_REQ && !iDATAIO_BUSY.
- Full check uses registered count only; same-cycle pop does not unblock.
- On issue_fire, push {tag, regname, rw, order, addr[1:0], signed}. Issue register refills the same cycle if a new op is offered.
- Lane i = bits [8i+7:8i]. Mask: byte = 1<<addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
- Misaligned half/word are aligned down. oDATAIO_ADDR = {addr[31:2], 2'b00}.
- Store data replication: byte to all four lanes, half to both halves.
- Response with count > 0: pop head; oWB_VALID = 1 the same cycle, combinationally.
  - oWB_WRITEBACK = !rw.
  - oWB_DATA: selected lane(s) shifted to bit 0, then zero- or sign-extended. Word passes through. Stores give 0.
- Response with count = 0 and b_discard = 0: ignored, oPROTOCOL_ERR set until reset.
- Flush (iRESET_SYNC):
  - Clears the issue register and FIFO pointers.
  - b_discard <= count + b_discard, minus 1 if a response arrives that cycle.
  - While b_discard != 0, each response decrements it and produces no oWB_VALID.
  - An issue_fire in the flush cycle is cancelled: oDATAIO_REQ is forced 0 while iRESET_SYNC.
- Reset: all registers 0. Outputs: oREQ_LOCK 0, oDATAIO_REQ 0, oWB_VALID 0, oOUTSTANDING 0, oPROTOCOL_ERR 0, data/attribute outputs 0.

## Timing
- Accept at edge N; oDATAIO_REQ high in cycle N+1 earliest.
- Sustained throughput is one issue per cycle with BUSY low and FIFO not full.
- Writeback latency is 0 cycles from iDATAIO_REQ.
- Earliest response is the cycle after issue_fire. A response in the issue_fire cycle for the same entry is illegal.
- Push and pop in the same cycle: count unchanged, both pointers advance, wrap modulo DEPTH.
- Request attributes are held stable while oDATAIO_REQ && iDATAIO_BUSY.

## Structure
- Shared core package/header holds:
  - order encodings LDST_ORDER_BYTE/HALF/WORD
  - mask-generation and load-align/extend functions, reused by other ports
- Sub-module ldst_outstanding_fifo: parametrised DEPTH x metadata-width register FIFO with push/pop/flush, count, full/empty.
- Top level contains the issue register, discard counter, store replication and load alignment.

## Test plan
- Word load addr 0x104, BUSY 0, response 0xDEADBEEF one cycle later -> mask 1111, addr 0x104, WB data 0xDEADBEEF, WRITEBACK 1, tag echoed.
- Signed byte load addr 0x103, response 0x80123456 -> mask 1000, WB 0xFFFFFF80. Unsigned -> 0x00000080.
- Half store addr 0x202, data 0x0000ABCD -> mask 1100, oDATAIO_DATA 0xABCDABCD. Ack gives WB_VALID with WRITEBACK 0.
- DEPTH=4: five back-to-back loads, no responses -> four issued, oDATAIO_REQ low, oREQ_LOCK high, oOUTSTANDING 4. One response -> 5th issues the next cycle.
- BUSY held 3 cycles -> request attributes stable, issue on the first BUSY-low cycle, one FIFO push.
- Flush with 3 outstanding -> next 3 responses produce no WB_VALID, lock held until the third. Then a new load completes normally with oPROTOCOL_ERR still 0. A stray extra response sets oPROTOCOL_ERR.
